cam_cmd_sequencer: RTL and testbench

//   Command sequencer between the USB-serial command parser and the CAM array.

---
 rtl/cam_cmd_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_cam_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cmd_sequencer.sv
// ============================================================================
// Module   : cam_cmd_sequencer
// Brief    : Single-outstanding command sequencer driving the CAM control lines.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_cmd_sequencer #(
  parameter int NUM_BITS      = 32,
  parameter int NUM_CELLS     = 16,
  parameter int PULSE_CYCLES  = 5,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [NUM_BITS-1:0]   cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NUM_BITS-1:0]   rsp_data,
  output logic                  rsp_err,
  output logic [NUM_BITS-1:0]   cam_comparand,
  output logic [NUM_BITS-1:0]   cam_mask,
  output logic                  cam_set,
  output logic                  cam_perform_search,
  output logic                  cam_select_first,
  output logic [2*NUM_BITS-1:0] cam_write_lines,
  input  logic [NUM_CELLS-1:0]  cam_tag_wires,
  input  logic [NUM_BITS-1:0]   cam_read_lines
);

  localparam logic [3:0] c_op_set_comp     = 4'h1;
  localparam logic [3:0] c_op_get_comp     = 4'h2;
  localparam logic [3:0] c_op_set_mask     = 4'h3;
  localparam logic [3:0] c_op_get_mask     = 4'h4;
  localparam logic [3:0] c_op_select_first = 4'h5;
  localparam logic [3:0] c_op_get_tags     = 4'h6;
  localparam logic [3:0] c_op_set_high     = 4'h7;
  localparam logic [3:0] c_op_set_low      = 4'h8;
  localparam logic [3:0] c_op_write        = 4'h9;
  localparam logic [3:0] c_op_read         = 4'hA;
  localparam logic [3:0] c_op_search       = 4'hB;

  // Counter runs load..0, so the phase lasts exactly (load + 1) cycles.
  localparam logic [15:0] c_pulse_load  = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] c_settle_load = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PULSE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_BITS-1:0]   comp_q, comp_d;
  logic [NUM_BITS-1:0]   mask_q, mask_d;
  logic                  set_q, set_d;
  logic                  search_q, search_d;
  logic                  selfirst_q, selfirst_d;
  logic [2*NUM_BITS-1:0] wl_q, wl_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [NUM_BITS-1:0]   rsp_data_q, rsp_data_d;

  logic                  w_accept;
  logic [2*NUM_BITS-1:0] w_rails;

  // Held in reset, nothing may be accepted even though the state reads IDLE.
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;

  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_rails
    assign w_rails[2*gi]   =  comp_q[gi] & mask_q[gi];
    assign w_rails[2*gi+1] = ~comp_q[gi] & mask_q[gi];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    comp_d      = comp_q;
    mask_d      = mask_q;
    set_d       = set_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    search_d    = 1'b0;
    selfirst_d  = 1'b0;
    wl_d        = '0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          op_d        = cmd_op;
          cnt_d       = '0;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          case (cmd_op)
            c_op_set_comp: comp_d     = cmd_data;
            c_op_set_mask: mask_d     = cmd_data;
            c_op_set_high: set_d      = 1'b1;
            c_op_set_low:  set_d      = 1'b0;
            c_op_get_comp: rsp_data_d = comp_q;
            c_op_get_mask: rsp_data_d = mask_q;
            c_op_search, c_op_select_first, c_op_write: begin
              state_d     = S_PULSE;
              cnt_d       = c_pulse_load;
              rsp_valid_d = 1'b0;
            end
            c_op_read, c_op_get_tags: begin
              state_d     = S_SETTLE;
              cnt_d       = c_settle_load;
              rsp_valid_d = 1'b0;
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
      end

      S_PULSE: begin
        if (cnt_q == 16'd0) begin
          state_d = S_SETTLE;
          cnt_d   = c_settle_load;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == 16'd0) begin
          state_d     = S_RESP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          if (op_q == c_op_read) begin
            rsp_data_d = cam_read_lines;
          end else if (op_q == c_op_get_tags) begin
            rsp_data_d[NUM_CELLS-1:0] = cam_tag_wires;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they never glitch.
    if (state_d == S_PULSE) begin
      search_d   = (op_d == c_op_search);
      selfirst_d = (op_d == c_op_select_first);
      wl_d       = (op_d == c_op_write) ? w_rails : '0;
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      comp_q      <= '0;
      mask_q      <= '0;
      set_q       <= 1'b0;
      search_q    <= 1'b0;
      selfirst_q  <= 1'b0;
      wl_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      comp_q      <= comp_d;
      mask_q      <= mask_d;
      set_q       <= set_d;
      search_q    <= search_d;
      selfirst_q  <= selfirst_d;
      wl_q        <= wl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid          = rsp_valid_q;
  assign rsp_err            = rsp_err_q;
  assign rsp_data           = rsp_data_q;
  assign cam_comparand      = comp_q;
  assign cam_mask           = mask_q;
  assign cam_set            = set_q;
  assign cam_perform_search = search_q;
  assign cam_select_first   = selfirst_q;
  assign cam_write_lines    = wl_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_cmd_sequencer.sv
// ============================================================================
// Module   : tb_cam_cmd_sequencer
// Brief    : Directed vector bench for cam_cmd_sequencer (32-bit, 16 cells).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cam_cmd_sequencer;

  logic        clk_48mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op    = 4'h0;
  logic [31:0] cmd_data  = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] cam_comparand;
  logic [31:0] cam_mask;
  logic        cam_set;
  logic        cam_perform_search;
  logic        cam_select_first;
  logic [63:0] cam_write_lines;
  logic [15:0] cam_tag_wires  = 16'h0;
  logic [31:0] cam_read_lines = 32'h0;

  int checks   = 0;
  int failures = 0;

  cam_cmd_sequencer #(
    .NUM_BITS(32), .NUM_CELLS(16), .PULSE_CYCLES(5), .SETTLE_CYCLES(10)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cam_comparand(cam_comparand), .cam_mask(cam_mask), .cam_set(cam_set),
    .cam_perform_search(cam_perform_search), .cam_select_first(cam_select_first),
    .cam_write_lines(cam_write_lines), .cam_tag_wires(cam_tag_wires),
    .cam_read_lines(cam_read_lines)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one command at a negedge and let it be accepted on the next posedge.
  task automatic accept(input logic [3:0] op, input logic [31:0] data);
    @(negedge clk_48mhz);
    chk("cmd_ready_before_accept", 72'(cmd_ready), 72'(1'b1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk_48mhz);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk_48mhz);
      lat++;
    end while (!rsp_valid && lat < 100);
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=no_response required=rsp_valid");
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk_48mhz);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [31:0] data,
                        output logic [31:0] d, output logic e, output int lat);
    accept(op, data);
    wait_rsp(lat);
    d = rsp_data;
    e = rsp_err;
    handshake();
  endtask

  // Cycle-by-cycle view of a strobed command: 5 pulse, 10 settle, response on 16.
  task automatic strobe_seq(input logic [3:0] op, input logic e_srch, input logic e_sel,
                            input logic [63:0] e_rails);
    logic pulse;
    accept(op, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_48mhz);
      pulse = (k <= 5);
      chk($sformatf("strobe_op%0h_cyc%0d", op, k),
          {4'h0, cmd_ready, rsp_valid, cam_perform_search, cam_select_first, cam_write_lines},
          {4'h0, 1'b0, (k == 16), pulse & e_srch, pulse & e_sel, pulse ? e_rails : 64'h0});
    end
    handshake();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    logic [31:0] rl;
    logic [15:0] tags;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_comp;
    logic [31:0] exp_mask;
    logic        exp_set;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    logic        seen;

    vecs[0]  = '{4'h1, 32'hDEADBEEF, 32'h0,        16'h0,    32'h0,        1'b0,  1, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{4'h2, 32'h12345678, 32'h0,        16'h0,    32'hDEADBEEF, 1'b0,  1, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[2]  = '{4'h3, 32'h0000FFFF, 32'h0,        16'h0,    32'h0,        1'b0,  1, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[3]  = '{4'h4, 32'hCAFEF00D, 32'h0,        16'h0,    32'h0000FFFF, 1'b0,  1, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[4]  = '{4'h7, 32'h0,        32'h0,        16'h0,    32'h0,        1'b0,  1, 32'hDEADBEEF, 32'h0000FFFF, 1'b1};
    vecs[5]  = '{4'hB, 32'h55555555, 32'h0,        16'h0,    32'h0,        1'b0, 16, 32'hDEADBEEF, 32'h0000FFFF, 1'b1};
    vecs[6]  = '{4'h8, 32'h0,        32'h0,        16'h0,    32'h0,        1'b0,  1, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[7]  = '{4'h5, 32'h0,        32'h0,        16'h0,    32'h0,        1'b0, 16, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[8]  = '{4'hA, 32'h0,        32'hA5A51234, 16'hFFFF, 32'hA5A51234, 1'b0, 11, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[9]  = '{4'h6, 32'h0,        32'hFFFFFFFF, 16'h8001, 32'h00008001, 1'b0, 11, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[10] = '{4'h0, 32'hFFFFFFFF, 32'h0,        16'h0,    32'h0,        1'b1,  1, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[11] = '{4'hF, 32'h0,        32'h0,        16'h0,    32'h0,        1'b1,  1, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[12] = '{4'hC, 32'h0,        32'h0,        16'h0,    32'h0,        1'b1,  1, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};
    vecs[13] = '{4'h9, 32'h0,        32'h0,        16'h0,    32'h0,        1'b0, 16, 32'hDEADBEEF, 32'h0000FFFF, 1'b0};

    #1;
    chk("reset_outputs",
        {cmd_ready, rsp_valid, rsp_err, cam_set, cam_perform_search, cam_select_first, 2'b00, 64'(cam_write_lines != 64'h0)},
        72'h0);
    chk("reset_regs", {8'h0, cam_comparand, cam_mask}, 72'h0);
    chk("reset_rsp_data", 72'(rsp_data), 72'h0);
    repeat (3) @(negedge clk_48mhz);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cam_read_lines = vecs[i].rl;
      cam_tag_wires  = vecs[i].tags;
      do_cmd(vecs[i].op, vecs[i].data, d, e, lat);
      chk($sformatf("vec%0d_data", i), 72'(d), 72'(vecs[i].exp_data));
      chk($sformatf("vec%0d_err", i), 72'(e), 72'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 72'(lat), 72'(vecs[i].exp_lat));
      @(negedge clk_48mhz);
      chk($sformatf("vec%0d_comp", i), 72'(cam_comparand), 72'(vecs[i].exp_comp));
      chk($sformatf("vec%0d_mask", i), 72'(cam_mask), 72'(vecs[i].exp_mask));
      chk($sformatf("vec%0d_set", i), 72'(cam_set), 72'(vecs[i].exp_set));
    end

    // WRITE rails with comp=F, mask=3, then SEARCH and SELECT_FIRST timing.
    do_cmd(4'h1, 32'h0000000F, d, e, lat);
    do_cmd(4'h3, 32'h00000003, d, e, lat);
    strobe_seq(4'h9, 1'b0, 1'b0, 64'h5);
    @(negedge clk_48mhz);
    chk("write_keeps_comp_mask", {8'h0, cam_comparand, cam_mask}, {8'h0, 32'h0000000F, 32'h00000003});
    strobe_seq(4'hB, 1'b1, 1'b0, 64'h0);
    strobe_seq(4'h5, 1'b0, 1'b1, 64'h0);

    // Illegal opcode held unacknowledged while a new command is offered.
    accept(4'hE, 32'hFFFFFFFF);
    wait_rsp(lat);
    chk("illegal_latency", 72'(lat), 72'd1);
    cmd_valid = 1'b1;
    cmd_op    = 4'h1;
    cmd_data  = 32'h11111111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_48mhz);
      chk($sformatf("hold_cyc%0d", k), {38'h0, rsp_valid, rsp_err, rsp_data, cmd_ready},
          {38'h0, 1'b1, 1'b1, 32'h0, 1'b0});
    end
    cmd_valid = 1'b0;
    @(negedge clk_48mhz);
    handshake();
    @(negedge clk_48mhz);
    chk("after_hold_release", {4'h0, rsp_valid, rsp_err, cmd_ready, 1'b0, cam_comparand, rsp_data},
        {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000000F, 32'h0});

    // Reset during the PULSE phase of SELECT_FIRST aborts without a response.
    do_cmd(4'h7, 32'h0, d, e, lat);
    @(negedge clk_48mhz);
    chk("set_high_level", 72'(cam_set), 72'(1'b1));
    accept(4'h5, 32'h0);
    @(negedge clk_48mhz);
    @(negedge clk_48mhz);
    chk("select_first_in_pulse", 72'(cam_select_first), 72'(1'b1));
    reset = 1'b1;
    #1;
    chk("midreset_strobes",
        {2'b00, cam_set, cam_perform_search, cam_select_first, cmd_ready, rsp_valid, 1'b0, cam_write_lines},
        72'h0);
    chk("midreset_regs", {8'h0, cam_comparand, cam_mask}, 72'h0);
    @(negedge clk_48mhz);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_48mhz);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_reset", 72'(seen), 72'(1'b0));
    chk("idle_after_reset", {cam_set, cmd_ready}, {1'b0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
